// File: rtl/wb_rr_arbiter_n.sv
// wb_rr_arbiter_n: N-port round-robin arbiter in front of one Wishbone classic
// master bus, with one transaction in flight at a time.
// Optional build macro WB_TIMEOUT_EN adds a bus watchdog. The watchdog ends a
// WAIT phase that lasts TIMEOUT_CYCLES cycles with an ack+err pulse.
// Handshake: a port holds i_port_req high until it samples o_port_ack[p]=1,
// and drops req on that edge. If req is still high in IDLE, it counts as a new
// request. Wishbone side: cyc=stb stay high, and o_wb_* stay stable, until the
// slave answers with ack or err.
// o_fsm_state exposes the controller state (0=IDLE, 1=WAIT, 2=DONE).
module wb_rr_arbiter_n #(
    parameter int NUM_PORTS      = 3,
    parameter int DATA_W         = 128,
    parameter int ADDR_W         = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_PORTS-1:0]          i_port_req,
    input  logic [NUM_PORTS-1:0]          i_port_write,
    input  logic [NUM_PORTS*DATA_W-1:0]   i_port_wdata,
    input  logic [NUM_PORTS*DATA_W/8-1:0] i_port_be,
    input  logic [NUM_PORTS*ADDR_W-1:0]   i_port_addr,
    output logic [NUM_PORTS-1:0]          o_port_ack,
    output logic [NUM_PORTS-1:0]          o_port_err,
    output logic [DATA_W-1:0]             o_port_rdata,
    output logic [ADDR_W-1:0]             o_wb_adr,
    output logic [DATA_W/8-1:0]           o_wb_sel,
    output logic                          o_wb_we,
    output logic [DATA_W-1:0]             o_wb_dat,
    output logic                          o_wb_cyc,
    output logic                          o_wb_stb,
    input  logic [DATA_W-1:0]             i_wb_dat,
    input  logic                          i_wb_ack,
    input  logic                          i_wb_err,
    output logic [1:0]                    o_fsm_state
);

    localparam int GW   = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
    localparam int BE_W = DATA_W / 8;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic [1:0]           state_q, state_d;
    logic [GW-1:0]        last_grant_q, last_grant_d;
    logic [GW-1:0]        grant_q, grant_d;
    logic [ADDR_W-1:0]    wb_adr_q, wb_adr_d;
    logic [BE_W-1:0]      wb_sel_q, wb_sel_d;
    logic                 wb_we_q, wb_we_d;
    logic [DATA_W-1:0]    wb_dat_q, wb_dat_d;
    logic                 wb_cyc_q, wb_cyc_d;
    logic [NUM_PORTS-1:0] port_ack_q, port_ack_d;
    logic [NUM_PORTS-1:0] port_err_q, port_err_d;
    logic [DATA_W-1:0]    port_rdata_q, port_rdata_d;

    logic                 req_any;
    logic [GW-1:0]        pick;
    logic                 tmo_hit;

    assign req_any = |i_port_req;

    // Round-robin pick: first requesting port after last_grant, wrapping to 0.
    always_comb begin
        logic          found;
        logic [GW-1:0] cand;
        int            idx;
        found = 1'b0;
        pick  = last_grant_q;
        cand  = '0;
        idx   = 0;
        for (int i = 1; i <= NUM_PORTS; i++) begin
            idx = int'(last_grant_q) + i;
            if (idx >= NUM_PORTS) idx = idx - NUM_PORTS;
            cand = GW'(idx);
            if (!found && i_port_req[cand]) begin
                found = 1'b1;
                pick  = cand;
            end
        end
    end

`ifdef WB_TIMEOUT_EN
    // The counter only has to reach TIMEOUT_CYCLES-1, because it starts at 0
    // on the first WAIT cycle.
    localparam int TMO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;

    assign tmo_hit = (tmo_cnt_q == TMO_W'(TIMEOUT_CYCLES - 1));

    // Watchdog count: cleared while idle, one step per WAIT cycle.
    always_comb begin
        tmo_cnt_d = tmo_cnt_q;
        if (state_q == ST_IDLE)      tmo_cnt_d = '0;
        else if (state_q == ST_WAIT) tmo_cnt_d = tmo_cnt_q + 1'b1;
    end

    // Watchdog counter register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) tmo_cnt_q <= '0;
        else        tmo_cnt_q <= tmo_cnt_d;
    end
`else
    // Without the watchdog, WAIT ends only on a slave ack or err.
    assign tmo_hit = 1'b0;
`endif

    // Next-state logic: grant in IDLE, complete in WAIT, pulse in DONE.
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        grant_d      = grant_q;
        wb_adr_d     = wb_adr_q;
        wb_sel_d     = wb_sel_q;
        wb_we_d      = wb_we_q;
        wb_dat_d     = wb_dat_q;
        wb_cyc_d     = wb_cyc_q;
        port_ack_d   = '0;
        port_err_d   = '0;
        port_rdata_d = port_rdata_q;
        case (state_q)
            ST_IDLE: begin
                if (req_any) begin
                    grant_d  = pick;
                    wb_adr_d = i_port_addr[int'(pick)*ADDR_W +: ADDR_W];
                    wb_sel_d = i_port_be[int'(pick)*BE_W +: BE_W];
                    wb_we_d  = i_port_write[pick];
                    wb_dat_d = i_port_wdata[int'(pick)*DATA_W +: DATA_W];
                    wb_cyc_d = 1'b1;
                    state_d  = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (i_wb_ack || i_wb_err) begin
                    wb_cyc_d            = 1'b0;
                    port_ack_d[grant_q] = 1'b1;
                    last_grant_d        = grant_q;
                    state_d             = ST_DONE;
                    if (i_wb_err) begin
                        port_err_d[grant_q] = 1'b1;
                        port_rdata_d        = '0;
                    end else begin
                        port_rdata_d = i_wb_dat;
                    end
                end else if (tmo_hit) begin
                    wb_cyc_d            = 1'b0;
                    port_ack_d[grant_q] = 1'b1;
                    port_err_d[grant_q] = 1'b1;
                    port_rdata_d        = '0;
                    last_grant_d        = grant_q;
                    state_d             = ST_DONE;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // State and output registers. The reset is asynchronous and drops cyc/stb
    // at once, with no completion pulse.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            last_grant_q <= GW'(NUM_PORTS - 1);
            grant_q      <= '0;
            wb_adr_q     <= '0;
            wb_sel_q     <= '0;
            wb_we_q      <= 1'b0;
            wb_dat_q     <= '0;
            wb_cyc_q     <= 1'b0;
            port_ack_q   <= '0;
            port_err_q   <= '0;
            port_rdata_q <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            grant_q      <= grant_d;
            wb_adr_q     <= wb_adr_d;
            wb_sel_q     <= wb_sel_d;
            wb_we_q      <= wb_we_d;
            wb_dat_q     <= wb_dat_d;
            wb_cyc_q     <= wb_cyc_d;
            port_ack_q   <= port_ack_d;
            port_err_q   <= port_err_d;
            port_rdata_q <= port_rdata_d;
        end
    end

    assign o_port_ack   = port_ack_q;
    assign o_port_err   = port_err_q;
    assign o_port_rdata = port_rdata_q;
    assign o_wb_adr     = wb_adr_q;
    assign o_wb_sel     = wb_sel_q;
    assign o_wb_we      = wb_we_q;
    assign o_wb_dat     = wb_dat_q;
    assign o_wb_cyc     = wb_cyc_q;
    assign o_wb_stb     = wb_cyc_q;
    assign o_fsm_state  = state_q;

endmodule

// File: tb/tb_wb_rr_arbiter_n.sv
// Directed bench for wb_rr_arbiter_n (3 ports, 128-bit data, 32-bit address).
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_wb_rr_arbiter_n;

    localparam int NP = 3;
    localparam int DW = 128;
    localparam int AW = 32;
    localparam int BW = DW / 8;

    logic              clk = 1'b0;
    logic              reset;
    logic [NP-1:0]     i_port_req;
    logic [NP-1:0]     i_port_write;
    logic [NP*DW-1:0]  i_port_wdata;
    logic [NP*BW-1:0]  i_port_be;
    logic [NP*AW-1:0]  i_port_addr;
    logic [NP-1:0]     o_port_ack;
    logic [NP-1:0]     o_port_err;
    logic [DW-1:0]     o_port_rdata;
    logic [AW-1:0]     o_wb_adr;
    logic [BW-1:0]     o_wb_sel;
    logic              o_wb_we;
    logic [DW-1:0]     o_wb_dat;
    logic              o_wb_cyc;
    logic              o_wb_stb;
    logic [DW-1:0]     i_wb_dat;
    logic              i_wb_ack;
    logic              i_wb_err;
    logic [1:0]        o_fsm_state;

    int checks = 0;
    int errors = 0;

    logic [NP-1:0] exp_q[$];

    // Clock and reset
    always #5 clk = ~clk;

    wb_rr_arbiter_n #(
        .NUM_PORTS(NP), .DATA_W(DW), .ADDR_W(AW), .TIMEOUT_CYCLES(8)
    ) dut (
        .clk(clk), .reset(reset),
        .i_port_req(i_port_req), .i_port_write(i_port_write),
        .i_port_wdata(i_port_wdata), .i_port_be(i_port_be),
        .i_port_addr(i_port_addr),
        .o_port_ack(o_port_ack), .o_port_err(o_port_err),
        .o_port_rdata(o_port_rdata),
        .o_wb_adr(o_wb_adr), .o_wb_sel(o_wb_sel), .o_wb_we(o_wb_we),
        .o_wb_dat(o_wb_dat), .o_wb_cyc(o_wb_cyc), .o_wb_stb(o_wb_stb),
        .i_wb_dat(i_wb_dat), .i_wb_ack(i_wb_ack), .i_wb_err(i_wb_err),
        .o_fsm_state(o_fsm_state)
    );

    // Scoreboard comparison
    task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Driver: load one port's request fields
    task automatic set_port(input int p, input logic wr, input logic [AW-1:0] adr,
                            input logic [BW-1:0] be, input logic [DW-1:0] wd);
        i_port_write[p]          = wr;
        i_port_addr[p*AW +: AW]  = adr;
        i_port_be[p*BW +: BW]    = be;
        i_port_wdata[p*DW +: DW] = wd;
    endtask

    // Slave driver: wait for cyc, insert wait states, answer, and return to
    // the caller at the DONE-cycle falling edge.
    task automatic serve(input int waits, input logic a, input logic e, input logic [DW-1:0] d,
                         output int cyc_cnt, output logic [AW-1:0] adr_s, output logic we_s,
                         output logic [BW-1:0] sel_s, output logic [DW-1:0] dat_s,
                         output logic [NP-1:0] ack_s, output logic [NP-1:0] err_s,
                         output logic [DW-1:0] rdata_s);
        int n;
        n = 0;
        while (!o_wb_cyc && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("cyc_rise", o_wb_cyc, 1'b1);
        check("stb_rise", o_wb_stb, 1'b1);
        adr_s   = o_wb_adr;
        we_s    = o_wb_we;
        sel_s   = o_wb_sel;
        dat_s   = o_wb_dat;
        cyc_cnt = 1;
        for (int w = 0; w < waits; w++) begin
            @(negedge clk);
            if (o_wb_cyc) cyc_cnt++;
        end
        i_wb_ack = a;
        i_wb_err = e;
        i_wb_dat = d;
        @(negedge clk);
        i_wb_ack = 1'b0;
        i_wb_err = 1'b0;
        i_wb_dat = {4{$urandom}};
        ack_s    = o_port_ack;
        err_s    = o_port_err;
        rdata_s  = o_port_rdata;
    endtask

    logic [AW-1:0] addr_tab [NP];
    int            cc;
    logic [AW-1:0] adr_s;
    logic          we_s;
    logic [BW-1:0] sel_s;
    logic [DW-1:0] dat_s;
    logic [NP-1:0] ack_s, err_s;
    logic [DW-1:0] rdata_s;
    logic [DW-1:0] d;
    logic [NP-1:0] exp_g;
    int            g;

    initial begin
        addr_tab[0] = 32'h0000_0100;
        addr_tab[1] = 32'h0000_1000;
        addr_tab[2] = 32'h0000_2200;
        i_wb_ack = 1'b0;
        i_wb_err = 1'b0;

        // 1: reset with random inputs
        reset = 1'b0;
        for (int k = 0; k < 4; k++) begin
            i_port_req   = NP'($urandom);
            i_port_write = NP'($urandom);
            i_port_wdata = {12{$urandom}};
            i_port_be    = 48'({2{$urandom}});
            i_port_addr  = {3{$urandom}};
            i_wb_dat     = {4{$urandom}};
            i_wb_ack     = 1'($urandom);
            i_wb_err     = 1'($urandom);
            @(negedge clk);
        end
        check("rst_cyc", o_wb_cyc, 1'b0);
        check("rst_stb", o_wb_stb, 1'b0);
        check("rst_ack", o_port_ack, 3'b000);
        check("rst_err", o_port_err, 3'b000);
        check("rst_rdata", o_port_rdata, '0);
        check("rst_adr", o_wb_adr, '0);
        check("rst_sel", o_wb_sel, '0);
        check("rst_we", o_wb_we, 1'b0);
        check("rst_dat", o_wb_dat, '0);
        check("rst_state", o_fsm_state, 2'd0);
        i_port_req = '0;
        i_port_write = '0;
        i_port_wdata = '0;
        i_port_be = '0;
        i_port_addr = '0;
        for (int p = 0; p < NP; p++)
            set_port(p, 1'b0, addr_tab[p], 16'hFFFF, {4{32'h1111_0000 + 32'(p)}});
        i_wb_ack = 1'b1;
        i_wb_err = 1'b1;
        reset = 1'b1;
        repeat (5) @(negedge clk);
        check("idle_cyc", o_wb_cyc, 1'b0);
        check("idle_ack_ignored", o_port_ack, 3'b000);
        check("idle_err_ignored", o_port_err, 3'b000);
        i_wb_ack = 1'b0;
        i_wb_err = 1'b0;

        // 2: single read on port 1, two wait states
        i_port_req = 3'b010;
        serve(2, 1'b1, 1'b0, {16{8'hA5}}, cc, adr_s, we_s, sel_s, dat_s, ack_s, err_s, rdata_s);
        check("rd_adr", adr_s, 32'h0000_1000);
        check("rd_we", we_s, 1'b0);
        check("rd_cyc_cycles", cc, 3);
        check("rd_ack", ack_s, 3'b010);
        check("rd_err", err_s, 3'b000);
        check("rd_rdata", rdata_s, {16{8'hA5}});
        check("rd_cyc_low", o_wb_cyc, 1'b0);
        check("rd_state_done", o_fsm_state, 2'd2);
        i_port_req = 3'b000;
        @(negedge clk);
        check("rd_ack_pulse", o_port_ack, 3'b000);
        check("rd_rdata_hold", o_port_rdata, {16{8'hA5}});

        // 3: round robin from a fresh reset, all ports requesting
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        for (int k = 0; k < 6; k++) exp_q.push_back(NP'(1 << (k % 3)));
        i_port_req = 3'b111;
        for (int k = 0; k < 6; k++) begin
            d = {4{32'hC0DE_0000 + 32'(k)}};
            serve(0, 1'b1, 1'b0, d, cc, adr_s, we_s, sel_s, dat_s, ack_s, err_s, rdata_s);
            exp_g = exp_q.pop_front();
            g = k % 3;
            check("rr_grant", ack_s, exp_g);
            check("rr_onehot", 32'($countones(ack_s)), 1);
            check("rr_adr", adr_s, addr_tab[g]);
            check("rr_rdata", rdata_s, d);
            i_port_req = i_port_req & ~ack_s;
            @(negedge clk);
            check("rr_idle_ack", o_port_ack, 3'b000);
            if (k < 5) i_port_req = 3'b111;
        end

        // 4: write on port 2 with ack and err together
        set_port(2, 1'b1, addr_tab[2], 16'h00FF, 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210);
        i_port_req = 3'b100;
        serve(1, 1'b1, 1'b1, {16{8'hEE}}, cc, adr_s, we_s, sel_s, dat_s, ack_s, err_s, rdata_s);
        check("wr_sel", sel_s, 16'h00FF);
        check("wr_we", we_s, 1'b1);
        check("wr_dat", dat_s, 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210);
        check("wr_adr", adr_s, 32'h0000_2200);
        check("wr_cyc_cycles", cc, 2);
        check("wr_ack", ack_s, 3'b100);
        check("wr_err", err_s, 3'b100);
        check("wr_rdata_zero", rdata_s, '0);
        i_port_req = 3'b000;
        set_port(2, 1'b0, addr_tab[2], 16'hFFFF, '0);
        @(negedge clk);

        // 5: reset in the middle of WAIT
        i_port_req = 3'b010;
        g = 0;
        while (!o_wb_cyc && g < 20) begin
            @(negedge clk);
            g++;
        end
        @(negedge clk);
        check("mid_cyc_before", o_wb_cyc, 1'b1);
        reset = 1'b0;
        #1;
        check("mid_cyc_drop", o_wb_cyc, 1'b0);
        check("mid_stb_drop", o_wb_stb, 1'b0);
        @(negedge clk);
        check("mid_no_ack", o_port_ack, 3'b000);
        i_port_req = 3'b111;
        reset = 1'b1;
        serve(0, 1'b1, 1'b0, {4{32'h5EED_0001}}, cc, adr_s, we_s, sel_s, dat_s, ack_s, err_s, rdata_s);
        check("mid_next_grant", ack_s, 3'b001);
        check("mid_next_adr", adr_s, 32'h0000_0100);
        i_port_req = 3'b000;
        @(negedge clk);

        // 6: silent slave
        i_port_req = 3'b001;
        g = 0;
        while (!o_wb_cyc && g < 20) begin
            @(negedge clk);
            g++;
        end
        check("tmo_cyc_rise", o_wb_cyc, 1'b1);
`ifdef WB_TIMEOUT_EN
        cc = 1;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (o_wb_cyc) cc++;
            else break;
        end
        check("tmo_cyc_cycles", cc, 8);
        check("tmo_ack", o_port_ack, 3'b001);
        check("tmo_err", o_port_err, 3'b001);
        check("tmo_rdata", o_port_rdata, '0);
        i_port_req = 3'b000;
        @(negedge clk);
        check("tmo_pulse_end", o_port_ack, 3'b000);
`else
        repeat (1000) @(negedge clk);
        check("notmo_cyc_held", o_wb_cyc, 1'b1);
        check("notmo_no_ack", o_port_ack, 3'b000);
        i_wb_ack = 1'b1;
        i_wb_dat = {4{32'h7777_0000}};
        @(negedge clk);
        i_wb_ack = 1'b0;
        check("notmo_late_ack", o_port_ack, 3'b001);
        check("notmo_rdata", o_port_rdata, {4{32'h7777_0000}});
        i_port_req = 3'b000;
        @(negedge clk);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
